// File: rtl/mips_data_mem_responder_if.sv
// Harvard data-port bundle between the CPU (master) and the data RAM responder (slave).
interface mips_data_mem_responder_if;
  logic        clk_enable;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  modport master (
    output clk_enable, data_address, data_read, data_write, data_writedata,
    input  data_readdata
  );

  modport slave (
    input  clk_enable, data_address, data_read, data_write, data_writedata,
    output data_readdata
  );
endinterface

// File: rtl/mips_data_mem_responder.sv
// Word-addressed data RAM for the CPU data port: zero-fill sweep after reset, sticky error flags.
// Optional access counters enabled by defining DMEM_ACCESS_CNT_EN.
module mips_data_mem_responder #(
  parameter int unsigned ADDR_W    = 5,
  parameter logic [31:0] BASE_ADDR = 32'h1000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  mips_data_mem_responder_if.slave bus,
  output logic                     mem_ready_o,
  output logic                     access_err_o,
  output logic [1:0]               err_code_o,
  output logic [CNT_W-1:0]         rd_count_o,
  output logic [CNT_W-1:0]         wr_count_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                access_err_q, access_err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [31:0]         mem_q [DEPTH];

  logic                ready;
  logic                hit;
  logic                aligned;
  logic                active;
  logic                rd_ok;
  logic                wr_ok;
  logic                err_any;
  logic [1:0]          err_sel;
  logic [ADDR_W-1:0]   index;

  // The window is aligned to its own size, so a hit is just a match of the upper address bits.
  assign ready   = (state_q == ST_READY);
  assign hit     = (bus.data_address[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign aligned = (bus.data_address[1:0] == 2'b00);
  assign index   = bus.data_address[ADDR_W+1:2];
  assign active  = ready & bus.clk_enable & (bus.data_read | bus.data_write);
  assign rd_ok   = ready & bus.data_read & ~bus.data_write & hit & aligned;
  assign wr_ok   = ready & bus.data_write & ~bus.data_read & hit & aligned & bus.clk_enable;

  assign bus.data_readdata = rd_ok ? mem_q[index] : 32'h0;

  always_comb begin
    err_sel = 2'b00;
    if (bus.data_read && bus.data_write) begin
      err_sel = 2'b11;
    end else if (!aligned) begin
      err_sel = 2'b01;
    end else if (!hit) begin
      err_sel = 2'b10;
    end
  end

  assign err_any = active & (err_sel != 2'b00);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    access_err_d = access_err_q;
    err_code_d   = err_code_q;
    case (state_q)
      ST_CLEAR: begin
        if (bus.clk_enable) begin
          if (&ptr_q) begin
            state_d = ST_READY;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      ST_READY: begin
        // Only the first error's code is kept; later ones just keep the flag set.
        if (err_any) begin
          access_err_d = 1'b1;
          if (!access_err_q) begin
            err_code_d = err_sel;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_CLEAR;
      ptr_q        <= '0;
      access_err_q <= 1'b0;
      err_code_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      access_err_q <= access_err_d;
      err_code_q   <= err_code_d;
    end
  end

  // The array has no reset; the sweep owns the write port until READY.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR && bus.clk_enable) begin
      mem_q[ptr_q] <= 32'h0;
    end else if (wr_ok) begin
      mem_q[index] <= bus.data_writedata;
    end
  end

  assign mem_ready_o  = ready;
  assign access_err_o = access_err_q;
  assign err_code_o   = err_code_q;

`ifdef DMEM_ACCESS_CNT_EN
  logic [CNT_W-1:0] rd_count_q, rd_count_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;

  assign rd_count_d = rd_count_q + CNT_W'(rd_ok & bus.clk_enable);
  assign wr_count_d = wr_count_q + CNT_W'(wr_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count_o = rd_count_q;
  assign wr_count_o = wr_count_q;
`else
  assign rd_count_o = '0;
  assign wr_count_o = '0;
`endif

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Randomised and directed bench for mips_data_mem_responder against an array-based reference model.
module tb_mips_data_mem_responder;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        mem_ready;
  logic        access_err;
  logic [1:0]  err_code;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  mips_data_mem_responder_if bus ();

  mips_data_mem_responder #(
    .ADDR_W(5),
    .BASE_ADDR(32'h1000),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .mem_ready_o(mem_ready),
    .access_err_o(access_err),
    .err_code_o(err_code),
    .rd_count_o(rd_count),
    .wr_count_o(wr_count)
  );

  always #5 clk = ~clk;

`ifdef DMEM_ACCESS_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: plain array plus flags, advanced once per clock edge.
  logic [31:0] mMem [32];
  bit          mReady;
  int          mSweep;
  bit          mErr;
  logic [1:0]  mCode;
  logic [15:0] mRd;
  logic [15:0] mWr;

  function automatic bit inWin(logic [31:0] a);
    return (a >= 32'h1000) && (a < 32'h1080);
  endfunction

  function automatic int wordIdx(logic [31:0] a);
    return int'((a - 32'h1000) / 4);
  endfunction

  function automatic logic [31:0] expRead();
    logic [31:0] a;
    a = bus.data_address;
    if (mReady && bus.data_read && !bus.data_write && inWin(a) && (a % 4 == 0))
      return mMem[wordIdx(a)];
    return 32'h0;
  endfunction

  function automatic logic [15:0] expRd();
    return CntEn ? mRd : 16'h0;
  endfunction

  function automatic logic [15:0] expWr();
    return CntEn ? mWr : 16'h0;
  endfunction

  function automatic void modelReset();
    mReady = 1'b0;
    mSweep = 0;
    mErr   = 1'b0;
    mCode  = 2'b00;
    mRd    = 16'h0;
    mWr    = 16'h0;
    for (int i = 0; i < 32; i++) mMem[i] = 32'h0;
  endfunction

  task automatic drive(input logic [31:0] a, input logic rd, input logic wr,
                       input logic [31:0] wd, input logic en);
    bus.data_address   = a;
    bus.data_read      = rd;
    bus.data_write     = wr;
    bus.data_writedata = wd;
    bus.clk_enable     = en;
    #1;
  endtask

  task automatic tick();
    logic [31:0] a;
    logic [1:0]  code;
    a = bus.data_address;
    if (!mReady) begin
      if (bus.clk_enable) begin
        mSweep++;
        if (mSweep == 32) mReady = 1'b1;
      end
    end else if (bus.clk_enable && (bus.data_read || bus.data_write)) begin
      code = 2'b00;
      if (bus.data_read && bus.data_write) code = 2'b11;
      else if (a % 4 != 0)                 code = 2'b01;
      else if (!inWin(a))                  code = 2'b10;
      if (code != 2'b00) begin
        if (!mErr) mCode = code;
        mErr = 1'b1;
      end else if (bus.data_write) begin
        mMem[wordIdx(a)] = bus.data_writedata;
        mWr++;
      end else begin
        mRd++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic holdReset();
    reset = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic bringUp();
    holdReset();
    repeat (32) tick();
  endtask

  task automatic test_reset();
    holdReset();
    bringUp();
    drive(32'h1010, 1'b0, 1'b1, 32'hCAFE0001, 1'b1);
    tick();
    drive(32'h1001, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    drive(32'h1010, 1'b1, 1'b0, 32'h0, 1'b1);
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checks++;
    if (mem_ready !== 1'b0 || access_err !== 1'b0 || err_code !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_flags: ready=%b err=%b code=%b required 0/0/00", mem_ready, access_err, err_code);
    end
    checks++;
    if (rd_count !== 16'h0 || wr_count !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_counts: rd=%0d wr=%0d required 0/0", rd_count, wr_count);
    end
    checks++;
    if (bus.data_readdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_readdata: got %h required 00000000", bus.data_readdata);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_sweep();
    holdReset();
    for (int i = 1; i <= 32; i++) begin
      drive(32'h1000, 1'b1, 1'b0, 32'h0, 1'b1);
      checks++;
      if (mem_ready !== 1'b0 || bus.data_readdata !== 32'h0) begin
        errors++;
        $display("[TB] FAIL sweep_cycle%0d: ready=%b rdata=%h required 0/0", i, mem_ready, bus.data_readdata);
      end
      tick();
    end
    checks++;
    if (mem_ready !== 1'b1 || access_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sweep_done: ready=%b err=%b required 1/0", mem_ready, access_err);
    end
    drive(32'h1000, 1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (bus.data_readdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL sweep_read0: got %h required 00000000", bus.data_readdata);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    logic [31:0] exp;
    addrs = '{32'h1004, 32'h107C, 32'h1000};
    datas = '{32'hDEADBEEF, 32'h0BADF00D, 32'h0};
    bringUp();
    drive(addrs[0], 1'b0, 1'b1, datas[0], 1'b1);
    tick();
    drive(addrs[1], 1'b0, 1'b1, datas[1], 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(addrs[i], 1'b1, 1'b0, 32'h0, 1'b1);
      exp = expRead();
      checks++;
      if (bus.data_readdata !== exp || exp !== datas[i]) begin
        errors++;
        $display("[TB] FAIL wr_rd_%h: got %h required %h", addrs[i], bus.data_readdata, datas[i]);
      end
      tick();
    end
    checks++;
    if (access_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wr_rd_noerr: err=%b required 0", access_err);
    end
  endtask

  task automatic test_misaligned();
    bringUp();
    drive(32'h1002, 1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (bus.data_readdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL misal_rdata: got %h required 00000000", bus.data_readdata);
    end
    tick();
    checks++;
    if (access_err !== mErr || err_code !== mCode || mCode !== 2'b01) begin
      errors++;
      $display("[TB] FAIL misal_code: err=%b code=%b required 1/01", access_err, err_code);
    end
    drive(32'h0FFC, 1'b0, 1'b1, 32'h55AA55AA, 1'b1);
    tick();
    checks++;
    if (access_err !== 1'b1 || err_code !== mCode) begin
      errors++;
      $display("[TB] FAIL misal_sticky: err=%b code=%b required 1/%b", access_err, err_code, mCode);
    end
    checks++;
    if (wr_count !== expWr()) begin
      errors++;
      $display("[TB] FAIL misal_nowrite: wr=%0d required %0d", wr_count, expWr());
    end
  endtask

  task automatic test_collision();
    logic [31:0] addrs [3];
    logic        rds   [3];
    logic [1:0]  codes [3];
    addrs = '{32'h1008, 32'h1080, 32'h0FFE};
    rds   = '{1'b1, 1'b1, 1'b0};
    codes = '{2'b11, 2'b10, 2'b01};
    for (int i = 0; i < 3; i++) begin
      bringUp();
      drive(addrs[i], rds[i], 1'b1 ^ (i == 1), 32'h12345678, 1'b1);
      tick();
      checks++;
      if (access_err !== 1'b1 || err_code !== mCode || mCode !== codes[i]) begin
        errors++;
        $display("[TB] FAIL err_prio_%h: err=%b code=%b required 1/%b", addrs[i], access_err, err_code, codes[i]);
      end
    end
    bringUp();
    drive(32'h1008, 1'b1, 1'b1, 32'h12345678, 1'b1);
    tick();
    drive(32'h1008, 1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (bus.data_readdata !== expRead() || err_code !== 2'b11) begin
      errors++;
      $display("[TB] FAIL collision_nowrite: rdata=%h code=%b required %h/11", bus.data_readdata, err_code, expRead());
    end
  endtask

  task automatic test_clk_enable();
    int cyc;
    bringUp();
    drive(32'h100C, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0);
    tick();
    drive(32'h1002, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    drive(32'h100C, 1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (bus.data_readdata !== expRead() || access_err !== mErr) begin
      errors++;
      $display("[TB] FAIL en0_frozen: rdata=%h err=%b required %h/%b", bus.data_readdata, access_err, expRead(), mErr);
    end
    holdReset();
    cyc = 0;
    while (!mReady && cyc < 100) begin
      drive(32'h0, 1'b0, 1'b0, 32'h0, (cyc < 10 || cyc >= 15));
      tick();
      cyc++;
      checks++;
      if (mem_ready !== mReady) begin
        errors++;
        $display("[TB] FAIL en0_sweep_c%0d: ready=%b required %b", cyc, mem_ready, mReady);
      end
    end
    checks++;
    if (cyc != 37 || mem_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL en0_sweep_len: cycles=%0d ready=%b required 37/1", cyc, mem_ready);
    end
  endtask

  task automatic test_reset_mid_sweep();
    holdReset();
    repeat (10) tick();
    #2;
    reset = 1'b0;
    modelReset();
    #1;
    checks++;
    if (mem_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midsweep_ready: got %b required 0", mem_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      checks++;
      if (mem_ready !== mReady) begin
        errors++;
        $display("[TB] FAIL midsweep_c%0d: ready=%b required %b", i, mem_ready, mReady);
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive(32'h1000 + 32'(4 * (i % 3)), (i >= 3), (i < 3), 32'hA0 + 32'(i), 1'b1);
      tick();
    end
    checks++;
    if (wr_count !== expWr() || rd_count !== expRd() || (CntEn && (mWr != 3 || mRd != 2))) begin
      errors++;
      $display("[TB] FAIL counters: wr=%0d rd=%0d required %0d/%0d", wr_count, rd_count, expWr(), expRd());
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] exp;
    int          op;
    int          kind;
    bringUp();
    for (int i = 0; i < 400; i++) begin
      op   = int'($urandom % 8);
      kind = int'($urandom % 16);
      a    = 32'h1000 + 32'(4 * ($urandom % 32));
      if (kind == 0) a = a + 32'(1 + $urandom % 3);
      if (kind == 1) a = (($urandom % 2) == 0) ? 32'h1080 + 32'(4 * ($urandom % 8)) : 32'h0FFC - 32'(4 * ($urandom % 8));
      // Errors are sticky, so keep most of the run error-free to exercise the data path.
      if (i < 300 && kind <= 1) a = 32'h1000 + 32'(4 * ($urandom % 32));
      drive(a, (op <= 2) || (op == 6 && i >= 300), (op >= 3 && op <= 5) || (op == 6 && i >= 300),
            $urandom, ($urandom % 5) != 0);
      exp = expRead();
      checks++;
      if (bus.data_readdata !== exp) begin
        errors++;
        $display("[TB] FAIL rand_rdata_%0d: addr=%h got %h required %h", i, a, bus.data_readdata, exp);
      end
      tick();
      checks++;
      if (access_err !== mErr || err_code !== mCode || rd_count !== expRd() || wr_count !== expWr()) begin
        errors++;
        $display("[TB] FAIL rand_state_%0d: err=%b code=%b rd=%0d wr=%0d required %b/%b/%0d/%0d",
                 i, access_err, err_code, rd_count, wr_count, mErr, mCode, expRd(), expWr());
      end
    end
  endtask

  initial begin
    modelReset();
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    test_reset();
    test_sweep();
    test_write_read();
    test_misaligned();
    test_collision();
    test_clk_enable();
    test_reset_mid_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
